fp_sqrt_pipe: RTL and testbench



---
 rtl/fp_sqrt_pkg.sv | 92 +++++++++
 rtl/fp_sqrt_if.sv | 26 ++
 rtl/fp_sqrt_lane.sv | 96 +++++++++
 rtl/fp_sqrt_pipe.sv | 50 +++++
 tb/tb_fp_sqrt_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types, constants and helpers for the FP32 square-root pipeline.
package fp_sqrt_pkg;

  localparam int EXP_W          = 8;
  localparam int FRAC_W         = 23;
  localparam int MANT_W         = 24;
  localparam int EXP_BIAS       = 127;
  localparam logic [31:0] CANON_QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF    = 32'h7F800000;
  localparam int LATENCY        = 16;

  // 24 significand bits + guard + round
  localparam int ROOT_W         = 26;
  // Radicand holds two bits per root bit
  localparam int RAD_W          = 2 * ROOT_W;
  // Signed remainder; |rem| stays well below 2^28
  localparam int REM_W          = 32;
  // Recurrence stages, two root bits each
  localparam int REC_STAGES     = 13;

  typedef struct packed {
    logic nan;   // force canonical qNaN (NaN in, or negative nonzero)
    logic zero;  // signed zero passes through
    logic inf;   // +inf passes through
  } sqrt_flags_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;    // biased result exponent before rounding carry
    logic [RAD_W-1:0]  rad;    // remaining radicand digits, MSB pair consumed first
    logic [ROOT_W-1:0] root;   // partial root
    logic [REM_W-1:0]  rem;    // two's-complement partial remainder
    sqrt_flags_t       flags;
  } lane_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    sqrt_flags_t       flags;
  } rounded_t;

  // Special-case classification of a raw FP32 operand
  function automatic sqrt_flags_t classify(input logic [31:0] a);
    sqrt_flags_t fl;
    logic        exp_max;
    logic        frac_zero;
    logic        is_zero;
    exp_max   = &a[30:23];
    frac_zero = (a[22:0] == '0);
    is_zero   = (a[30:23] == '0) && frac_zero;
    fl.nan    = (exp_max & ~frac_zero) | (a[31] & ~is_zero);
    fl.zero   = is_zero;
    fl.inf    = exp_max & frac_zero & ~a[31];
    return fl;
  endfunction

  // Leading-zero count of a 24-bit mantissa (24 when all zero)
  function automatic logic [4:0] lzc24(input logic [MANT_W-1:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(MANT_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // One non-restoring square-root iteration: consumes a radicand pair, yields one root bit
  function automatic lane_state_t nr_step(input lane_state_t s);
    lane_state_t      o;
    logic [REM_W-1:0] sh;
    logic [REM_W-1:0] q4;
    o  = s;
    sh = (s.rem << 2) | {{(REM_W-2){1'b0}}, s.rad[RAD_W-1 -: 2]};
    if (!s.rem[REM_W-1]) begin
      q4    = {4'b0000, s.root, 2'b01};
      o.rem = sh - q4;
    end else begin
      q4    = {4'b0000, s.root, 2'b11};
      o.rem = sh + q4;
    end
    o.root = (s.root << 1) | {{(ROOT_W-1){1'b0}}, ~o.rem[REM_W-1]};
    o.rad  = s.rad << 2;
    return o;
  endfunction

endpackage

// File: rtl/fp_sqrt_if.sv
// Request/response bundle of the square-root unit: valid/ready in, valid/ready out.
interface fp_sqrt_if #(
  parameter int TAGW  = 1,
  parameter int LANES = 1
);
  logic                  valid_in;
  logic                  ready_in;
  logic [TAGW-1:0]       tag_in;
  logic [LANES*32-1:0]   dataa;
  logic [LANES*32-1:0]   result;
  logic [TAGW-1:0]       tag_out;
  logic                  valid_out;
  logic                  ready_out;

  // Upstream requester plus downstream consumer
  modport master (
    output valid_in, tag_in, dataa, ready_out,
    input  ready_in, result, tag_out, valid_out
  );

  // The square-root unit itself
  modport slave (
    input  valid_in, tag_in, dataa, ready_out,
    output ready_in, result, tag_out, valid_out
  );
endinterface

// File: rtl/fp_sqrt_lane.sv
// Single-lane 16-stage FP32 square root: unpack, 13 recurrence stages, round, pack.
module fp_sqrt_lane
  import fp_sqrt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] a,
  output logic [31:0] y
);

  lane_state_t unpack_next;
  lane_state_t st_reg [REC_STAGES+1];
  rounded_t    rnd_next;
  rounded_t    rnd_reg;
  logic [31:0] pack_next;
  logic [31:0] y_reg;

  // Unpack: normalise subnormals, make the exponent even, seed the recurrence
  always_comb begin
    logic              is_sub;
    logic [MANT_W-1:0] mant;
    logic [4:0]        lz;
    logic signed [9:0] ue;
    logic signed [9:0] half;
    logic [MANT_W:0]   msh;
    is_sub = (a[30:23] == '0);
    mant   = {~is_sub, a[22:0]};
    lz     = is_sub ? lzc24(mant) : 5'd0;
    mant   = mant << lz;
    ue     = is_sub ? (-10'sd126 - $signed({5'b00000, lz}))
                    : ($signed({2'b00, a[30:23]}) - 10'sd127);
    half   = ue >>> 1;
    // odd exponent: fold one factor of two into the radicand
    msh    = ue[0] ? {mant, 1'b0} : {1'b0, mant};
    unpack_next       = '0;
    unpack_next.sign  = a[31];
    unpack_next.exp   = 8'(half + 10'sd127);
    unpack_next.rad   = {msh, {(RAD_W-MANT_W-1){1'b0}}};
    unpack_next.flags = classify(a);
  end

  // Stage 1 capture and stages 2..14 of the digit recurrence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= REC_STAGES; i++) st_reg[i] <= '0;
    end else if (enable) begin
      st_reg[0] <= unpack_next;
      for (int i = 0; i < REC_STAGES; i++) st_reg[i+1] <= nr_step(nr_step(st_reg[i]));
    end
  end

  // Round to nearest even using guard, round and remainder sticky
  always_comb begin
    logic [REM_W-1:0] rem_fix;
    logic             sticky;
    logic             up;
    logic [MANT_W:0]  mant_r;
    rem_fix = st_reg[REC_STAGES].rem[REM_W-1]
            ? (st_reg[REC_STAGES].rem + {5'b00000, st_reg[REC_STAGES].root, 1'b1})
            : st_reg[REC_STAGES].rem;
    sticky  = |rem_fix;
    up      = st_reg[REC_STAGES].root[1] &
              (st_reg[REC_STAGES].root[0] | sticky | st_reg[REC_STAGES].root[2]);
    mant_r  = {1'b0, st_reg[REC_STAGES].root[ROOT_W-1:2]} + {{MANT_W{1'b0}}, up};
    rnd_next       = '0;
    rnd_next.sign  = st_reg[REC_STAGES].sign;
    rnd_next.flags = st_reg[REC_STAGES].flags;
    // mantissa carry-out leaves frac at zero and bumps the exponent
    rnd_next.exp   = st_reg[REC_STAGES].exp + {7'b0000000, mant_r[MANT_W]};
    rnd_next.frac  = mant_r[FRAC_W-1:0];
  end

  // Stage 15 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rnd_reg <= '0;
    else if (enable) rnd_reg <= rnd_next;
  end

  // Pack and apply special-case overrides
  always_comb begin
    pack_next = {1'b0, rnd_reg.exp, rnd_reg.frac};
    if (rnd_reg.flags.nan)       pack_next = CANON_QNAN;
    else if (rnd_reg.flags.zero) pack_next = {rnd_reg.sign, 31'b0};
    else if (rnd_reg.flags.inf)  pack_next = POS_INF;
  end

  // Stage 16 output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      y_reg <= '0;
    else if (enable) y_reg <= pack_next;
  end

  assign y = y_reg;

endmodule

// File: rtl/fp_sqrt_pipe.sv
// Multi-lane FP32 square root with shared valid/tag pipeline and whole-pipe stall.
module fp_sqrt_pipe
  import fp_sqrt_pkg::*;
#(
  parameter int TAGW  = 1,
  parameter int LANES = 1
) (
  input logic      clk,
  input logic      reset,
  fp_sqrt_if.slave bus
);

  logic                         stall;
  logic                         enable;
  logic [LATENCY-1:0]           vld_reg;
  logic [LATENCY-1:0][TAGW-1:0] tag_reg;
  logic [LANES*32-1:0]          result_w;

  // An unconsumed output freezes every stage, so nothing is lost or duplicated
  assign stall         = bus.valid_out & ~bus.ready_out;
  assign enable        = ~stall;
  assign bus.ready_in  = enable;
  assign bus.valid_out = vld_reg[LATENCY-1];
  assign bus.tag_out   = tag_reg[LATENCY-1];
  assign bus.result    = result_w;

  // Valid/tag delay line; bubbles advance like real requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_reg <= '0;
      tag_reg <= '0;
    end else if (enable) begin
      vld_reg <= {vld_reg[LATENCY-2:0], bus.valid_in};
      tag_reg <= {tag_reg[LATENCY-2:0], bus.tag_in};
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      fp_sqrt_lane u_lane (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .a      (bus.dataa[32*gi +: 32]),
        .y      (result_w[32*gi +: 32])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fp_sqrt_pipe.sv
// Scoreboard bench for fp_sqrt_pipe: directed FP32 vectors, 4 lanes.
`timescale 1ns/1ps
module tb_fp_sqrt_pipe;

  localparam int TAGW  = 4;
  localparam int LANES = 4;
  localparam int DW    = LANES * 32;
  localparam int NV    = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_sqrt_if #(.TAGW(TAGW), .LANES(LANES)) bus ();

  fp_sqrt_pipe #(.TAGW(TAGW), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-computed operand/result pairs
  logic [31:0] vin [NV] = '{
    32'h40800000, 32'h40000000, 32'h00000001, 32'h3F800000, 32'hBF800000,
    32'h80000000, 32'h7F800000, 32'h7FA00000, 32'h00000000, 32'h41800000,
    32'hC0000000, 32'h00800000, 32'h40400000, 32'h41100000, 32'h3E800000,
    32'hFF800000, 32'h807FFFFF, 32'h7FC00001, 32'h3F000000, 32'h00400000};
  logic [31:0] vout [NV] = '{
    32'h40000000, 32'h3FB504F3, 32'h1A3504F3, 32'h3F800000, 32'h7FC00000,
    32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h40800000,
    32'h7FC00000, 32'h20000000, 32'h3FDDB3D7, 32'h40400000, 32'h3F000000,
    32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h3F3504F3, 32'h1FB504F3};

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Present one request from a negedge; push its expectation when it is accepted
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e, input logic [TAGW-1:0] t);
    int guard;
    guard = 0;
    bus.valid_in = 1'b1;
    bus.dataa    = d;
    bus.tag_in   = t;
    while (!bus.ready_in && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_in stayed 0, expected 1 within 100 cycles");
    end else begin
      exp_q.push_back('{data: e, tag: t});
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic send_idx(input int i0, input int i1, input int i2, input int i3,
                          input logic [TAGW-1:0] t);
    send({vin[i3], vin[i2], vin[i1], vin[i0]}, {vout[i3], vout[i2], vout[i1], vout[i0]}, t);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", DW'(exp_q.size()), DW'(0));
  endtask

  // Monitor: a handshake completes at the next posedge when valid_out & ready_out
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %h result %h, expected no output",
                   bus.tag_out, bus.result);
        end else begin
          e = exp_q.pop_front();
          $display("OUT tag=%h result=%h", bus.tag_out, bus.result);
          chk("result", bus.result, e.data);
          chk("tag_out", DW'(bus.tag_out), DW'(e.tag));
        end
      end
    end
  end

  initial begin : stim
    int              cnt;
    logic [DW-1:0]   held_res;
    logic [TAGW-1:0] held_tag;
    reset         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.tag_in    = '0;
    bus.dataa     = '0;
    bus.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid_out", DW'(bus.valid_out), DW'(1'b0));
    chk("reset_result", bus.result, DW'(0));
    chk("reset_tag_out", DW'(bus.tag_out), DW'(0));
    reset = 1'b1;
    @(negedge clk);

    // Basic latency: 4.0 -> 2.0, tag 1
    bus.valid_in = 1'b1;
    bus.dataa    = {4{32'h40800000}};
    bus.tag_in   = 4'd1;
    chk("ready_in_idle", DW'(bus.ready_in), DW'(1'b1));
    exp_q.push_back('{data: {4{32'h40000000}}, tag: 4'd1});
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) bus.valid_in = 1'b0;
    end while (!bus.valid_out && cnt < 40);
    chk("latency", DW'(cnt), DW'(16));
    @(negedge clk);
    chk("valid_one_cycle", DW'(bus.valid_out), DW'(1'b0));

    // Rounding / subnormal stream, back to back
    send_idx(1, 2, 3, 19, 4'd2);
    send_idx(2, 3, 1, 18, 4'd3);
    send_idx(3, 1, 2, 12, 4'd4);
    // Specials
    send_idx(4, 5, 6, 7, 4'd5);
    send_idx(8, 15, 16, 17, 4'd6);
    // Multi-lane mix: 16, 2, -2, min normal
    send_idx(9, 1, 10, 11, 4'd7);
    drain();

    // Fill the pipe, then backpressure while an output is presented
    for (int k = 0; k < 20; k++)
      send_idx(k % NV, (k + 5) % NV, (k + 11) % NV, (k + 17) % NV, TAGW'(k));
    chk("valid_before_stall", DW'(bus.valid_out), DW'(1'b1));
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    bus.dataa     = {vin[13], vin[12], vin[14], vin[0]};
    bus.tag_in    = 4'hA;
    #1;
    chk("ready_in_stalled", DW'(bus.ready_in), DW'(1'b0));
    held_res = bus.result;
    held_tag = bus.tag_out;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready_in", DW'(bus.ready_in), DW'(1'b0));
      chk("stall_valid_out", DW'(bus.valid_out), DW'(1'b1));
      chk("stall_result_hold", bus.result, held_res);
      chk("stall_tag_hold", DW'(bus.tag_out), DW'(held_tag));
    end
    bus.ready_out = 1'b1;
    exp_q.push_back('{data: {vout[13], vout[12], vout[14], vout[0]}, tag: 4'hA});
    @(negedge clk);
    bus.valid_in = 1'b0;
    send_idx(12, 13, 14, 18, 4'hB);
    send_idx(19, 0, 2, 11, 4'hC);
    drain();

    // Reset with requests in flight
    for (int k = 0; k < 20; k++)
      send_idx((k + 3) % NV, (k + 7) % NV, (k + 13) % NV, k % NV, TAGW'(k + 1));
    chk("valid_before_reset", DW'(bus.valid_out), DW'(1'b1));
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_async_valid", DW'(bus.valid_out), DW'(1'b0));
    chk("reset_async_result", bus.result, DW'(0));
    chk("reset_async_tag", DW'(bus.tag_out), DW'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("valid_after_reset", DW'(bus.valid_out), DW'(1'b0));
    end
    send_idx(12, 13, 14, 9, 4'hF);
    drain();
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
